// File: rtl/rock_sequencer_if.sv
// Command/setting bundle between the control logic and rock_sequencer.
// master = control side (issues commands), slave = the sequencer.
//
// Handshake: Start and Stop are single-cycle command pulses with no ready
// path; the sequencer samples them on every rising edge and always accepts
// them. TargetFreq/TargetAmp only need to be valid in the cycle Start is
// high. Done is a single-cycle status pulse; Freq/Amp/State/Busy are
// registered levels that are valid every cycle after reset.
interface rock_sequencer_if;
  logic       Start;
  logic       Stop;
  logic [2:0] TargetFreq;
  logic [2:0] TargetAmp;
  logic [2:0] Freq;
  logic [2:0] Amp;
  logic [1:0] State;
  logic       Busy;
  logic       Done;

  modport master (
    output Start, Stop, TargetFreq, TargetAmp,
    input  Freq, Amp, State, Busy, Done
  );

  modport slave (
    input  Start, Stop, TargetFreq, TargetAmp,
    output Freq, Amp, State, Busy, Done
  );
endinterface

// File: rtl/rock_sequencer.sv
// rock_sequencer: soft-start/soft-stop slew sequencer for the cradle output
// stage. Freq/Amp move one level per STEP_CYCLES toward the latched target
// (SLEW), hold it (RUN) and ramp back to 0 (STOP) before going IDLE.
// Optional build macro ROCK_TIMEOUT_EN: RUN ends on its own after
// RUN_CYCLES cycles and the sequencer ramps down as if Stop had arrived.
// State is exported on the interface so checkers can bind to the FSM.
module rock_sequencer #(
  parameter int unsigned STEP_CYCLES = 50_000_000,
  parameter logic [31:0] RUN_CYCLES  = 32'd1_800_000_000
) (
  input logic             CLK,
  input logic             Reset,
  rock_sequencer_if.slave bus
);

  // Reject illegal configurations at elaboration.
  if (STEP_CYCLES < 2) begin : g_bad_step
    $error("rock_sequencer: STEP_CYCLES must be at least 2");
  end
  if (RUN_CYCLES < 32'd2) begin : g_bad_run
    $error("rock_sequencer: RUN_CYCLES must be at least 2");
  end

  localparam logic [31:0] STEP_LAST = 32'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SLEW = 2'd1,
    S_RUN  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  freq, amp, freq_nx, amp_nx;
  logic [2:0]  tf, ta, tf_nx, ta_nx;
  logic [31:0] step_cnt;
  logic        done;
  logic        restart;
  logic        tick;
  logic        zero_tgt, stop_req, start_req;
  logic        run_expired;
  logic [2:0]  goal_f, goal_a, freq_step, amp_step;

  // One level toward goal, never past it, so values stay inside 0..7.
  function automatic logic [2:0] step_toward(input logic [2:0] v, input logic [2:0] goal);
    logic [2:0] r;
    r = v;
    if (v < goal) r = v + 3'd1;
    else if (v > goal) r = v - 3'd1;
    return r;
  endfunction

  assign tick      = (step_cnt == STEP_LAST);
  assign zero_tgt  = (bus.TargetFreq == 3'd0) && (bus.TargetAmp == 3'd0);
  // A zero-target Start acts as Stop; Stop beats a simultaneous Start.
  assign stop_req  = bus.Stop || (bus.Start && zero_tgt);
  assign start_req = bus.Start && !bus.Stop && !zero_tgt;

  assign goal_f    = (state == S_STOP) ? 3'd0 : tf;
  assign goal_a    = (state == S_STOP) ? 3'd0 : ta;
  assign freq_step = step_toward(freq, goal_f);
  assign amp_step  = step_toward(amp, goal_a);

`ifdef ROCK_TIMEOUT_EN
  logic [31:0] run_cnt;

  // Run counter: zero outside RUN, so it starts from 0 on every RUN entry.
  always_ff @(posedge CLK) begin
    if (Reset || (state != S_RUN)) run_cnt <= 32'd0;
    else                           run_cnt <= run_cnt + 32'd1;
  end

  assign run_expired = (run_cnt == RUN_CYCLES - 32'd1);
`else
  assign run_expired = 1'b0;
`endif

  // Next-state, slew and target-latch decisions.
  always_comb begin
    state_nx = state;
    freq_nx  = freq;
    amp_nx   = amp;
    tf_nx    = tf;
    ta_nx    = ta;
    restart  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_req) begin
          state_nx = S_SLEW;
          tf_nx    = bus.TargetFreq;
          ta_nx    = bus.TargetAmp;
        end
      end
      S_SLEW: begin
        if (stop_req) begin
          state_nx = S_STOP;
        end else if (start_req) begin
          // New targets restart the step period from the current values.
          tf_nx   = bus.TargetFreq;
          ta_nx   = bus.TargetAmp;
          restart = 1'b1;
        end else if (tick) begin
          freq_nx = freq_step;
          amp_nx  = amp_step;
          if ((freq_step == tf) && (amp_step == ta)) state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (stop_req) begin
          state_nx = S_STOP;
        end else if (start_req) begin
          state_nx = S_SLEW;
          tf_nx    = bus.TargetFreq;
          ta_nx    = bus.TargetAmp;
        end else if (run_expired) begin
          state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (start_req) begin
          state_nx = S_SLEW;
          tf_nx    = bus.TargetFreq;
          ta_nx    = bus.TargetAmp;
        end else if (tick) begin
          freq_nx = freq_step;
          amp_nx  = amp_step;
          if ((freq_step == 3'd0) && (amp_step == 3'd0)) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, settings, targets, step counter and Done pulse registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= S_IDLE;
      freq     <= 3'd0;
      amp      <= 3'd0;
      tf       <= 3'd0;
      ta       <= 3'd0;
      step_cnt <= 32'd0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      freq  <= freq_nx;
      amp   <= amp_nx;
      tf    <= tf_nx;
      ta    <= ta_nx;
      done  <= (state == S_STOP) && (state_nx == S_IDLE);
      if ((state_nx != state) || (state == S_IDLE) || restart || tick)
        step_cnt <= 32'd0;
      else
        step_cnt <= step_cnt + 32'd1;
    end
  end

  assign bus.Freq  = freq;
  assign bus.Amp   = amp;
  assign bus.State = state;
  assign bus.Busy  = (state != S_IDLE);
  assign bus.Done  = done;

endmodule

// File: tb/tb_rock_sequencer.sv
// Testbench for rock_sequencer (STEP_CYCLES=4, RUN_CYCLES=20).
// The reference model describes each command as a segment (kind, start
// cycle, start values, goal) and computes the outputs of any later cycle in
// closed form from elapsed time; a driver pushes the expected outputs of
// each cycle into exp_q and a negedge monitor pops and compares.
module tb_rock_sequencer;
  localparam int S  = 4;
  localparam int RC = 20;

  localparam int K_IDLE = 0;
  localparam int K_SLEW = 1;
  localparam int K_STOP = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rock_sequencer_if bus ();

  rock_sequencer #(
    .STEP_CYCLES(S),
    .RUN_CYCLES (32'(RC))
  ) dut (
    .CLK  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  // ---------------- reference model ----------------
  int seg_kind, seg_n, seg_f0, seg_a0, seg_tf, seg_ta;
  int cyc;

  function automatic int absd(int x, int y);
    return (x > y) ? x - y : y - x;
  endfunction

  function automatic int max3(int x, int y, int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

  // Value after n one-level steps from v toward goal (stops at goal).
  function automatic int move_to(int v, int goal, int n);
    if (v < goal) return (v + n < goal) ? v + n : goal;
    return (v - n > goal) ? v - n : goal;
  endfunction

  // Expected {State, Freq, Amp, Busy, Done} in cycle t.
  function automatic logic [9:0] model_at(int t);
    int kind, n, f0, a0, k, ticks, d, st, f, a;
    bit dn;
`ifdef ROCK_TIMEOUT_EN
    int run_entry;
`endif
    kind = seg_kind; n = seg_n; f0 = seg_f0; a0 = seg_a0;
    st = 0; f = 0; a = 0; dn = 1'b0;
    if (kind == K_SLEW) begin
      k = t - n - 1;
      ticks = k / S;
      d = max3(absd(f0, seg_tf), absd(a0, seg_ta), 1);
      if (ticks < d) begin
        st = 1;
        f = move_to(f0, seg_tf, ticks);
        a = move_to(a0, seg_ta, ticks);
      end else begin
        st = 2; f = seg_tf; a = seg_ta;
`ifdef ROCK_TIMEOUT_EN
        run_entry = n + 1 + d * S;
        if (t >= run_entry + RC) begin
          kind = K_STOP; n = run_entry + RC - 1; f0 = seg_tf; a0 = seg_ta;
        end
`endif
      end
    end
    if (kind == K_STOP) begin
      k = t - n - 1;
      ticks = k / S;
      d = max3(f0, a0, 1);
      if (ticks < d) begin
        st = 3;
        f = move_to(f0, 0, ticks);
        a = move_to(a0, 0, ticks);
      end else begin
        st = 0; f = 0; a = 0;
        dn = (k == d * S);
      end
    end
    return {st[1:0], f[2:0], a[2:0], (st != 0), dn};
  endfunction

  task automatic set_seg(int kind, int n, int f0, int a0, int tf, int ta);
    seg_kind = kind; seg_n = n; seg_f0 = f0; seg_a0 = a0; seg_tf = tf; seg_ta = ta;
  endtask

  // Apply the command sampled in cycle n to the model.
  task automatic model_cmd(int n, bit r, bit st, bit sp, int tf, int ta);
    logic [9:0] cur;
    int cst, cf, ca;
    bit zero, stop_like, go;
    cur  = model_at(n);
    cst  = int'(cur[9:8]);
    cf   = int'(cur[7:5]);
    ca   = int'(cur[4:2]);
    zero = (tf == 0) && (ta == 0);
    stop_like = sp || (st && zero);
    go   = st && !sp && !zero;
    if (r) begin
      set_seg(K_IDLE, n, 0, 0, 0, 0);
    end else begin
      case (cst)
        0: if (go) set_seg(K_SLEW, n, 0, 0, tf, ta);
        1, 2: begin
          if (stop_like) set_seg(K_STOP, n, cf, ca, 0, 0);
          else if (go)   set_seg(K_SLEW, n, cf, ca, tf, ta);
        end
        default: if (go) set_seg(K_SLEW, n, cf, ca, tf, ta);
      endcase
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  logic [9:0] exp_v, act_v;
  int compared = 0;
  int mismatched = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {bus.State, bus.Freq, bus.Amp, bus.Busy, bus.Done};
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("FAIL outputs @%0t: got State=%0d Freq=%0d Amp=%0d Busy=%0b Done=%0b, want State=%0d Freq=%0d Amp=%0d Busy=%0b Done=%0b",
                 $time, act_v[9:8], act_v[7:5], act_v[4:2], act_v[1], act_v[0],
                 exp_v[9:8], exp_v[7:5], exp_v[4:2], exp_v[1], exp_v[0]);
      end
    end
  end

  task automatic check_val(string name, int got, int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(bit r, bit st, bit sp, logic [2:0] tf, logic [2:0] ta);
    @(posedge clk);
    #1;
    cyc++;
    exp_q.push_back(model_at(cyc));
    rst            = r;
    bus.Start      = st;
    bus.Stop       = sp;
    bus.TargetFreq = tf;
    bus.TargetAmp  = ta;
    model_cmd(cyc, r, st, sp, int'(tf), int'(ta));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic random_phase(int n);
    int r, nst;
    bit st, sp, rs;
    logic [2:0] tf, ta;
    for (int i = 0; i < n; i++) begin
      r   = $urandom_range(0, 999);
      nst = int'(model_at(cyc + 1) >> 8);
      rs  = (r < 3);
      st  = (r >= 3) && (r < 40) && (nst != 1);
      sp  = (r >= 30) && (r < 60);
      tf  = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      ta  = ($urandom_range(0, 5) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      drive(rs, st, sp, tf, ta);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.Start = 1'b0;
    bus.Stop = 1'b0;
    bus.TargetFreq = 3'd0;
    bus.TargetAmp = 3'd0;
    cyc = 0;
    set_seg(K_IDLE, 0, 0, 0, 0, 0);

    idle(2);
    // Ramp up to 3/2, hold, ramp down.
    drive(1'b0, 1'b1, 1'b0, 3'd3, 3'd2);
    idle(30);
    drive(1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
    idle(40);
    // Retarget in RUN, then Start+Stop together.
    drive(1'b0, 1'b1, 1'b0, 3'd3, 3'd2);
    idle(16);
    drive(1'b0, 1'b1, 1'b0, 3'd1, 3'd5);
    idle(16);
    drive(1'b0, 1'b1, 1'b1, 3'd6, 3'd6);
    idle(40);
    // Zero-target Start in IDLE is ignored.
    drive(1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
    idle(5);
    // Reset mid-ramp with a Start pulse during Reset.
    drive(1'b0, 1'b1, 1'b0, 3'd7, 3'd7);
    idle(10);
    drive(1'b1, 1'b1, 1'b0, 3'd5, 3'd5);
    idle(1);
    #1;
    check_val("reset State", int'(bus.State), 0);
    check_val("reset Freq",  int'(bus.Freq),  0);
    check_val("reset Amp",   int'(bus.Amp),   0);
    check_val("reset Busy",  int'(bus.Busy),  0);
    idle(2);
    // Start while ramping down resumes slewing from current values.
    drive(1'b0, 1'b1, 1'b0, 3'd2, 3'd6);
    idle(8);
    drive(1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 3'd4, 3'd1);
    idle(40);
    // Long hold in RUN (timeout build ramps down by itself).
    drive(1'b0, 1'b1, 1'b0, 3'd1, 3'd1);
    idle(110);
    #1;
`ifdef ROCK_TIMEOUT_EN
    check_val("expired wait State", int'(bus.State), 0);
    check_val("expired wait Freq",  int'(bus.Freq),  0);
    check_val("expired wait Amp",   int'(bus.Amp),   0);
`else
    check_val("expired wait State", int'(bus.State), 2);
    check_val("expired wait Freq",  int'(bus.Freq),  1);
    check_val("expired wait Amp",   int'(bus.Amp),   1);
`endif
    drive(1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
    idle(30);

    random_phase(4000);
    idle(60);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
